hello_rotate_ctrl: RTL and testbench

- Sequential upstream stage for the HELLO rotating-display datapath.
- Generates the 3-bit rotation select that drives the five 3-bit 5-to-1 character muxes, replacing the manual SW[17:15] setting.
- Auto-rotates at a programmable rate, holds on pause, reverses direction, and single-steps from a debounced pushbutton.
- Output rot_sel connects directly to the mux select inputs. Only codes 0..4 are ever produced.

---
 rtl/hello_rotate_ctrl_if.sv | 22 ++
 rtl/hello_rotate_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_hello_rotate_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hello_rotate_ctrl_if.sv
// Control/status bundle between the HELLO rotation controller and its user.
// The master side drives the operator controls (run, dir, step button, rate).
// The slave side (the controller) returns the mux select and status.
interface hello_rotate_ctrl_if;
   logic       run;
   logic       dir;
   logic       step_n;
   logic [1:0] rate_sel;
   logic [2:0] rot_sel;
   logic       tick;
   logic       running;

   modport master (
      output run, dir, step_n, rate_sel,
      input  rot_sel, tick, running
   );

   modport slave (
      input  run, dir, step_n, rate_sel,
      output rot_sel, tick, running
   );
endinterface

// File: rtl/hello_rotate_ctrl.sv
// HELLO rotating-display controller.
// Produces the 3-bit rotation select (0..4) for the five character muxes.
// Rotation advances either from a programmable-rate prescaler (run=1) or from
// a synchronized, debounced pushbutton; both sources merge into one advance
// strobe so coincident events move the display by exactly one position.
module hello_rotate_ctrl #(
   parameter int CLK_HZ     = 50000000,
   parameter int STEP_HZ    = 1,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   hello_rotate_ctrl_if.slave  bus
);

   // Prescaler sizing: the x1 period is the longest, so it fixes the width.
   localparam int TICK_DIV = CLK_HZ / STEP_HZ;
   localparam int PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   // Debounce counter only ever needs to reach DEB_CYCLES-1.
   localparam int              DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      REL_STABLE,   // button accepted as released
      REL_WAIT,     // low seen while released, qualifying the press
      PRS_STABLE,   // button accepted as pressed
      PRS_WAIT      // high seen while pressed, qualifying the release
   } deb_state_t;

   genvar gi;

   // ------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------
   logic [1:0]       sync_reg;
   logic             s_btn;

   deb_state_t       deb_state_reg, deb_state_next;
   logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
   logic             step_pulse;

   logic [PRE_W-1:0] term_tbl [4];
   logic [PRE_W-1:0] term;
   logic [PRE_W-1:0] pre_reg, pre_next;
   logic             adv_auto;

   logic             adv;
   logic [2:0]       rot_reg, rot_next;
   logic             tick_reg;
   logic             running_reg;

   // ------------------------------------------------------------------
   // Button synchronizer: idles high (released) so reset never looks like
   // a press; only the second stage feeds the debouncer.
   // ------------------------------------------------------------------
   // Two-flop synchronizer for the asynchronous pushbutton.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], bus.step_n};
      end
   end

   assign s_btn = sync_reg[1];

   // ------------------------------------------------------------------
   // Debounce FSM
   // ------------------------------------------------------------------
   // Debounce state and qualification counter registers.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         deb_state_reg <= REL_STABLE;
         deb_cnt_reg   <= '0;
      end else begin
         deb_state_reg <= deb_state_next;
         deb_cnt_reg   <= deb_cnt_next;
      end
   end

   // Debounce next-state: a level change must persist through the whole
   // qualification window; the press edge emits a single step pulse.
   always_comb begin
      deb_state_next = deb_state_reg;
      deb_cnt_next   = deb_cnt_reg;
      step_pulse     = 1'b0;
      case (deb_state_reg)
         REL_STABLE: begin
            if (!s_btn) begin
               deb_state_next = REL_WAIT;
               deb_cnt_next   = '0;
            end
         end
         REL_WAIT: begin
            if (s_btn) begin
               deb_state_next = REL_STABLE;
            end else if (deb_cnt_reg == DEB_LAST) begin
               deb_state_next = PRS_STABLE;
               step_pulse     = 1'b1;
            end else begin
               deb_cnt_next = deb_cnt_reg + 1'b1;
            end
         end
         PRS_STABLE: begin
            if (s_btn) begin
               deb_state_next = PRS_WAIT;
               deb_cnt_next   = '0;
            end
         end
         PRS_WAIT: begin
            if (!s_btn) begin
               deb_state_next = PRS_STABLE;
            end else if (deb_cnt_reg == DEB_LAST) begin
               deb_state_next = REL_STABLE;
            end else begin
               deb_cnt_next = deb_cnt_reg + 1'b1;
            end
         end
         default: begin
            deb_state_next = REL_STABLE;
            deb_cnt_next   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Prescaler
   // ------------------------------------------------------------------
   // Terminal count per rate setting: each step of rate_sel halves the period.
   for (gi = 0; gi < 4; gi++) begin : g_term
      assign term_tbl[gi] = PRE_W'((TICK_DIV >> gi) - 1);
   end

   assign term = term_tbl[bus.rate_sel];

   // Prescaler count register.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         pre_reg <= '0;
      end else begin
         pre_reg <= pre_next;
      end
   end

   // Prescaler next-count: the >= compare lets a faster rate picked mid-count
   // fire immediately rather than wrapping the counter; paused means parked
   // at zero so a resume always waits one full period.
   always_comb begin
      pre_next = '0;
      adv_auto = 1'b0;
      if (bus.run) begin
         if (pre_reg >= term) begin
            adv_auto = 1'b1;
         end else begin
            pre_next = pre_reg + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Rotation select
   // ------------------------------------------------------------------
   assign adv = adv_auto | step_pulse;

   // Rotation next-value: modulo-5 up/down step; any illegal code recovers to 0.
   always_comb begin
      rot_next = rot_reg;
      if (rot_reg > 3'd4) begin
         rot_next = 3'd0;
      end else if (adv) begin
         if (!bus.dir) begin
            rot_next = (rot_reg == 3'd4) ? 3'd0 : rot_reg + 3'd1;
         end else begin
            rot_next = (rot_reg == 3'd0) ? 3'd4 : rot_reg - 3'd1;
         end
      end
   end

   // Output registers: select, its change strobe, and the run status copy.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         rot_reg     <= 3'd0;
         tick_reg    <= 1'b0;
         running_reg <= 1'b0;
      end else begin
         rot_reg     <= rot_next;
         tick_reg    <= adv;
         running_reg <= bus.run;
      end
   end

   assign bus.rot_sel = rot_reg;
   assign bus.tick    = tick_reg;
   assign bus.running = running_reg;

endmodule

// File: tb/tb_hello_rotate_ctrl.sv
// Bench for hello_rotate_ctrl: directed phases plus a random soak.
// A cycle-level reference model (accepted button level with a run-length
// count, an elapsed-cycle prescaler, modulo-5 position) pushes the expected
// outputs for every clock into a queue; a negedge monitor pops and compares.
module tb_hello_rotate_ctrl;

   localparam int CLK_HZ     = 100;
   localparam int STEP_HZ    = 10;
   localparam int DEB_CYCLES = 4;
   localparam int TICK_DIV   = CLK_HZ / STEP_HZ;

   typedef struct {
      logic       tick;
      logic [2:0] rot;
      logic       running;
   } exp_t;

   logic clk    = 1'b0;
   logic resetn = 1'b1;

   hello_rotate_ctrl_if bus();

   hello_rotate_ctrl #(
      .CLK_HZ     (CLK_HZ),
      .STEP_HZ    (STEP_HZ),
      .DEB_CYCLES (DEB_CYCLES)
   ) dut (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t q[$];
   exp_t mon_e;

   // reference model state
   int   m_rot, m_pc, m_run_len;
   logic m_acc, m_h1, m_h2;

   task automatic model_reset();
      m_rot     = 0;
      m_pc      = 0;
      m_run_len = 0;
      m_acc     = 1'b1;
      m_h1      = 1'b1;
      m_h2      = 1'b1;
   endtask

   // One clock edge of the model, using the inputs the DUT sampled.
   task automatic model_edge();
      logic s, stp, auto_adv;
      exp_t e;
      // button seen two edges late, accepted after DEB_CYCLES+1 differing samples
      s    = m_h2;
      m_h2 = m_h1;
      m_h1 = bus.step_n;
      stp  = 1'b0;
      if (s != m_acc) begin
         m_run_len++;
         if (m_run_len == DEB_CYCLES + 1) begin
            m_acc     = s;
            m_run_len = 0;
            stp       = (s == 1'b0);
         end
      end else begin
         m_run_len = 0;
      end
      // auto advance once per (TICK_DIV >> rate) cycles of run
      auto_adv = 1'b0;
      if (bus.run) begin
         if (m_pc >= (TICK_DIV >> bus.rate_sel) - 1) begin
            auto_adv = 1'b1;
            m_pc     = 0;
         end else begin
            m_pc++;
         end
      end else begin
         m_pc = 0;
      end
      if (auto_adv || stp) m_rot = bus.dir ? (m_rot + 4) % 5 : (m_rot + 1) % 5;
      e.tick    = auto_adv | stp;
      e.rot     = 3'(m_rot);
      e.running = bus.run;
      q.push_back(e);
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (resetn) model_edge();
         #1;
      end
   endtask

   task automatic press(input int low, input int high);
      bus.step_n = 1'b0;
      cycles(low);
      bus.step_n = 1'b1;
      cycles(high);
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Asynchronous reset between edges; outputs must clear at once.
   task automatic do_reset();
      resetn = 1'b0;
      #1;
      chk("reset_rot_sel", int'(bus.rot_sel), 0);
      chk("reset_tick", int'(bus.tick), 0);
      chk("reset_running", int'(bus.running), 0);
      q.delete();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   // Monitor: one expected record per clock edge.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         n_vec++;
         if (bus.rot_sel !== mon_e.rot || bus.tick !== mon_e.tick ||
             bus.running !== mon_e.running) begin
            n_err++;
            $display("FAIL outputs cycle %0d: rot_sel=%0d tick=%0b running=%0b, expected rot_sel=%0d tick=%0b running=%0b",
                     cyc, bus.rot_sel, bus.tick, bus.running,
                     mon_e.rot, mon_e.tick, mon_e.running);
         end
      end
   end

   initial begin
      int hold;
      bus.run      = 1'b0;
      bus.dir      = 1'b0;
      bus.step_n   = 1'b1;
      bus.rate_sel = 2'b00;
      model_reset();
      #2;
      do_reset();

      // 1: forward auto rotation at x1
      bus.run = 1'b1;
      cycles(60);

      // 2: reverse with wrap, then x8 (advance every cycle)
      bus.dir = 1'b1;
      cycles(30);
      bus.rate_sel = 2'b11;
      cycles(12);

      // 3: pause, then single steps from the button
      bus.run      = 1'b0;
      bus.rate_sel = 2'b00;
      bus.dir      = 1'b0;
      cycles(50);
      press(20, 20);
      press(20, 20);

      // 4: bounce rejection, then a clean press
      press(1, 1);
      press(2, 1);
      press(3, 1);
      cycles(10);
      press(10, 15);

      // 5a: step pulse lands on the prescaler terminal cycle
      bus.run = 1'b1;
      for (int i = 0; i < 20 && m_pc != 3; i++) cycles(1);
      press(7, 12);
      // 5b: rate raised mid-count
      for (int i = 0; i < 20 && m_pc != 6; i++) cycles(1);
      bus.rate_sel = 2'b11;
      cycles(5);
      bus.rate_sel = 2'b00;

      // 6: async reset at rot_sel=3 while a release is being qualified
      bus.run = 1'b0;
      cycles(5);
      for (int i = 0; i < 6 && m_rot != 2; i++) press(8, 10);
      bus.step_n = 1'b0;
      cycles(8);
      chk("model_at_3", m_rot, 3);
      bus.step_n = 1'b1;
      cycles(4);
      do_reset();
      cycles(20);
      press(10, 10);

      // 7: random soak
      hold = 1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            bus.run      = 1'($urandom_range(0, 1));
            bus.dir      = 1'($urandom_range(0, 1));
            bus.rate_sel = 2'($urandom_range(0, 3));
         end
         hold--;
         if (hold == 0) begin
            bus.step_n = ~bus.step_n;
            hold       = $urandom_range(1, 12);
         end
         cycles(1);
      end
      bus.step_n = 1'b1;
      cycles(20);

      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
